// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement sequencer between the ROB head and the
// register file commit port; also owns the store-commit handshake, the
// pipeline clear/redirect pulse and the halt flag.
module commit_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              head_valid,
  input  logic              head_ready,
  input  logic [1:0]        head_type,
  input  logic [TAG_W-1:0]  head_tag,
  input  logic [REG_W-1:0]  head_reg_dest,
  input  logic [DATA_W-1:0] head_data,
  input  logic              head_mispredict,
  input  logic [DATA_W-1:0] head_target_pc,
  output logic              rob_pop,
  output logic              rf_wr_valid,
  output logic [REG_W-1:0]  rf_wr_dest,
  output logic [TAG_W-1:0]  rf_wr_tag,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              st_commit_req,
  output logic [TAG_W-1:0]  st_commit_tag,
  input  logic              st_commit_ack,
  output logic              clear,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halt,
  output logic [31:0]       retire_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_ALU    = 2'b00;
  localparam logic [1:0] TYPE_STORE  = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b10;

  state_t state, state_next;
  logic   wr_set;
  logic   flush_set;
  logic   store_set;
  logic   store_done;
  logic   halt_set;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Retirement decision: next state, pop and one-cycle set strobes for the outputs
  always_comb begin
    state_next = state;
    rob_pop    = 1'b0;
    wr_set     = 1'b0;
    flush_set  = 1'b0;
    store_set  = 1'b0;
    store_done = 1'b0;
    halt_set   = 1'b0;
    if (rdy) begin
      case (state)
        RUN: begin
          if (head_valid && head_ready) begin
            case (head_type)
              TYPE_ALU: begin
                rob_pop = 1'b1;
                wr_set  = (head_reg_dest != '0);
              end
              TYPE_BRANCH: begin
                rob_pop = 1'b1;
                wr_set  = (head_reg_dest != '0);
                if (head_mispredict) begin
                  flush_set  = 1'b1;
                  state_next = FLUSH;
                end
              end
              TYPE_STORE: begin
                store_set  = 1'b1;
                state_next = STORE_WAIT;
              end
              default: begin
                rob_pop    = 1'b1;
                halt_set   = 1'b1;
                state_next = HALTED;
              end
            endcase
          end
        end
        STORE_WAIT: begin
          if (st_commit_ack) begin
            rob_pop    = 1'b1;
            store_done = 1'b1;
            state_next = RUN;
          end
        end
        FLUSH:   state_next = RUN;
        default: state_next = HALTED;
      endcase
    end
  end

  // Registered commit-side outputs; data fields only move with their strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_valid    <= 1'b0;
      rf_wr_dest     <= '0;
      rf_wr_tag      <= '0;
      rf_wr_data     <= '0;
      st_commit_req  <= 1'b0;
      st_commit_tag  <= '0;
      clear          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      halt           <= 1'b0;
      retire_count   <= '0;
    end else begin
      rf_wr_valid    <= wr_set;
      clear          <= flush_set;
      redirect_valid <= flush_set;
      if (wr_set) begin
        rf_wr_dest <= head_reg_dest;
        rf_wr_tag  <= head_tag;
        rf_wr_data <= head_data;
      end
      if (flush_set) redirect_pc <= head_target_pc;
      if (store_set) begin
        st_commit_req <= 1'b1;
        st_commit_tag <= head_tag;
      end else if (store_done) begin
        st_commit_req <= 1'b0;
      end
      if (halt_set) halt <= 1'b1;
      if (rob_pop) retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl with a cycle-level reference model of the
// retirement rules and a few literal checkpoints pinning that model.
module tb_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        head_valid;
  logic        head_ready;
  logic [1:0]  head_type;
  logic [3:0]  head_tag;
  logic [4:0]  head_reg_dest;
  logic [31:0] head_data;
  logic        head_mispredict;
  logic [31:0] head_target_pc;
  logic        rob_pop;
  logic        rf_wr_valid;
  logic [4:0]  rf_wr_dest;
  logic [3:0]  rf_wr_tag;
  logic [31:0] rf_wr_data;
  logic        st_commit_req;
  logic [3:0]  st_commit_tag;
  logic        st_commit_ack;
  logic        clear;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_bad = 0;

  commit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
    .head_tag(head_tag), .head_reg_dest(head_reg_dest), .head_data(head_data),
    .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
    .rob_pop(rob_pop), .rf_wr_valid(rf_wr_valid), .rf_wr_dest(rf_wr_dest),
    .rf_wr_tag(rf_wr_tag), .rf_wr_data(rf_wr_data),
    .st_commit_req(st_commit_req), .st_commit_tag(st_commit_tag),
    .st_commit_ack(st_commit_ack), .clear(clear),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be, derived from the retirement rules
  bit          armed = 0;
  bit          m_store_pending, m_bubble, m_halted;
  logic        m_wr_valid, m_clear, m_redir, m_req;
  logic [4:0]  m_dest;
  logic [3:0]  m_wtag, m_stag;
  logic [31:0] m_data, m_pc, m_count;

  always @(negedge clk) begin
    bit can_fire, exp_pop;
    can_fire = rdy && !m_store_pending && !m_bubble && !m_halted && head_valid && head_ready;
    exp_pop  = (can_fire && head_type != 2'b01) || (rdy && m_store_pending && st_commit_ack);
    if (armed) begin
      check("rob_pop",        64'(rob_pop),        64'(exp_pop));
      check("rf_wr_valid",    64'(rf_wr_valid),    64'(m_wr_valid));
      check("rf_wr_dest",     64'(rf_wr_dest),     64'(m_dest));
      check("rf_wr_tag",      64'(rf_wr_tag),      64'(m_wtag));
      check("rf_wr_data",     64'(rf_wr_data),     64'(m_data));
      check("st_commit_req",  64'(st_commit_req),  64'(m_req));
      check("st_commit_tag",  64'(st_commit_tag),  64'(m_stag));
      check("clear",          64'(clear),          64'(m_clear));
      check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
      check("redirect_pc",    64'(redirect_pc),    64'(m_pc));
      check("halt",           64'(halt),           64'(m_halted));
      check("retire_count",   64'(retire_count),   64'(m_count));
    end
    if (rst) begin
      armed = 1;
      m_store_pending = 0; m_bubble = 0; m_halted = 0;
      m_wr_valid = 0; m_clear = 0; m_redir = 0; m_req = 0;
      m_dest = '0; m_wtag = '0; m_stag = '0; m_data = '0; m_pc = '0; m_count = '0;
    end else if (!rdy) begin
      m_wr_valid = 0; m_clear = 0; m_redir = 0;
    end else begin
      m_wr_valid = 0; m_clear = 0; m_redir = 0; m_bubble = 0;
      if (can_fire) begin
        if (head_type == 2'b00 || head_type == 2'b10) begin
          m_count = m_count + 1;
          if (head_reg_dest != 0) begin
            m_wr_valid = 1; m_dest = head_reg_dest; m_wtag = head_tag; m_data = head_data;
          end
          if (head_type == 2'b10 && head_mispredict) begin
            m_clear = 1; m_redir = 1; m_pc = head_target_pc; m_bubble = 1;
          end
        end else if (head_type == 2'b01) begin
          m_store_pending = 1; m_req = 1; m_stag = head_tag;
        end else begin
          m_count = m_count + 1; m_halted = 1;
        end
      end else if (m_store_pending && st_commit_ack) begin
        m_count = m_count + 1; m_store_pending = 0; m_req = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic v, input logic [1:0] t, input logic [3:0] tag,
                          input logic [4:0] dest, input logic [31:0] data,
                          input logic mp, input logic [31:0] tgt);
    head_valid = v; head_ready = v; head_type = t; head_tag = tag;
    head_reg_dest = dest; head_data = data; head_mispredict = mp; head_target_pc = tgt;
  endtask

  task automatic idle();
    set_head(1'b0, 2'b00, 4'd0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; rdy = 1; st_commit_ack = 0;
    idle();
    step(); step();
    at_neg();
    check("reset_count", 64'(retire_count), 64'd0);
    check("reset_req",   64'(st_commit_req), 64'd0);
    rst = 0;

    // ALU burst: x1<-0x11, x2<-0x22, x0<-0x33
    step(); set_head(1, 2'b00, 4'd1, 5'd1, 32'h11, 0, 0);
    step(); set_head(1, 2'b00, 4'd2, 5'd2, 32'h22, 0, 0);
    at_neg(); check("burst_wr_x1", 64'(rf_wr_data), 64'h11);
    step(); set_head(1, 2'b00, 4'd3, 5'd0, 32'h33, 0, 0);
    step(); idle();
    at_neg();
    check("burst_count",  64'(retire_count), 64'd3);
    check("burst_x0_nowr", 64'(rf_wr_valid), 64'd0);
    check("burst_hold",   64'(rf_wr_data),   64'h22);

    // Mispredicted branch with a ready ALU head behind it
    step(); set_head(1, 2'b10, 4'd4, 5'd1, 32'h104, 1, 32'h200);
    step(); set_head(1, 2'b00, 4'd5, 5'd3, 32'h55, 0, 0);
    at_neg();
    check("mp_clear",   64'(clear),       64'd1);
    check("mp_pc",      64'(redirect_pc), 64'h200);
    check("mp_wr_data", 64'(rf_wr_data),  64'h104);
    check("mp_no_fire", 64'(rob_pop),     64'd0);
    step();
    at_neg(); check("mp_next_fire", 64'(rob_pop), 64'd1);
    step(); idle();
    at_neg(); check("mp_count", 64'(retire_count), 64'd5);

    // Store with ack delayed four cycles
    step(); set_head(1, 2'b01, 4'd5, 5'd0, 32'd0, 0, 0);
    at_neg(); check("st_no_pop", 64'(rob_pop), 64'd0);
    step(); step(); step();
    at_neg(); check("st_tag", 64'(st_commit_tag), 64'd5);
    step(); st_commit_ack = 1;
    at_neg(); check("st_ack_pop", 64'(rob_pop), 64'd1);
    step(); st_commit_ack = 0; idle();
    at_neg();
    check("st_req_low", 64'(st_commit_req), 64'd0);
    check("st_count",   64'(retire_count),  64'd6);

    // rdy stall on a ready ALU head
    step(); rdy = 0; set_head(1, 2'b00, 4'd6, 5'd4, 32'h44, 0, 0);
    at_neg(); check("stall_no_pop", 64'(rob_pop), 64'd0);
    step(); step();
    step(); rdy = 1;
    step(); idle();
    at_neg();
    check("stall_count", 64'(retire_count), 64'd7);
    check("stall_wr",    64'(rf_wr_data),   64'h44);

    // rdy stall during STORE_WAIT with ack asserted
    step(); set_head(1, 2'b01, 4'd6, 5'd0, 32'd0, 0, 0);
    step(); rdy = 0; st_commit_ack = 1;
    step();
    at_neg(); check("stall_req_held", 64'(st_commit_req), 64'd1);
    step(); rdy = 1;
    step(); st_commit_ack = 0; idle();
    at_neg(); check("stall_st_count", 64'(retire_count), 64'd8);

    // Reset in STORE_WAIT, then a stale ack
    step(); set_head(1, 2'b01, 4'd7, 5'd0, 32'd0, 0, 0);
    step(); idle(); rst = 1;
    step(); rst = 0; st_commit_ack = 1;
    at_neg();
    check("rst_count",   64'(retire_count),  64'd0);
    check("rst_req",     64'(st_commit_req), 64'd0);
    check("stale_ack",   64'(rob_pop),       64'd0);
    step(); st_commit_ack = 0;

    // Halt followed by more ready heads
    step(); set_head(1, 2'b00, 4'd1, 5'd1, 32'h9, 0, 0);
    step(); set_head(1, 2'b11, 4'd8, 5'd0, 32'd0, 0, 0);
    step(); set_head(1, 2'b00, 4'd9, 5'd2, 32'h77, 0, 0);
    at_neg();
    check("halt_set",    64'(halt),         64'd1);
    check("halt_no_pop", 64'(rob_pop),      64'd0);
    step(); step();
    at_neg();
    check("halt_count",  64'(retire_count), 64'd2);
    check("halt_no_wr",  64'(rf_wr_valid),  64'd0);
    step(); idle(); rst = 1;
    step(); rst = 0;
    at_neg(); check("halt_cleared", 64'(halt), 64'd0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order retirement controller between the reorder buffer head and the register file write port. Each cycle it inspects the ROB head entry and decides whether to retire it. Retiring means one of:
- Write the result to the architectural register file.
- Complete a store handshake with the load/store unit.
- Flush the pipeline and redirect fetch on a branch mispredict.
- Halt.

It is the only sequencer of the register file's commit-side write port and of the global `clear` pulse.

## Interface
Parameters:
- DATA_W, 32, data/PC width
- TAG_W, 4, ROB tag width
- REG_W, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; 0 freezes the block
- head_valid  in  1  ROB non-empty
- head_ready  in  1  head result available
- head_type  in  2  00 ALU/load, 01 store, 10 branch/jump, 11 halt
- head_tag  in  TAG_W  head ROB tag
- head_reg_dest  in  REG_W  destination register
- head_data  in  DATA_W  result / link value
- head_mispredict  in  1  branch outcome mismatched prediction
- head_target_pc  in  DATA_W  correct next PC for a mispredicted branch
- rob_pop  out  1  combinational; head retired this cycle
- rf_wr_valid  out  1  registered register file write strobe
- rf_wr_dest  out  REG_W  write index
- rf_wr_tag  out  TAG_W  tag of the writing entry
- rf_wr_data  out  DATA_W  write data
- st_commit_req  out  1  registered; request memory commit of the head store
- st_commit_tag  out  TAG_W  tag of that store
- st_commit_ack  in  1  load/store unit finished the store
- clear  out  1  registered one-cycle pipeline flush
- redirect_valid  out  1  registered one-cycle fetch redirect
- redirect_pc  out  DATA_W  redirect target
- halt  out  1  sticky; program ended
- retire_count  out  32  retired instruction count

## Operation
- States: RUN, STORE_WAIT, FLUSH, HALTED.
- A head entry *fires* when all of these hold: `rdy`, state RUN, `head_valid`, `head_ready`.
- On fire, by `head_type`:
  - **00 (ALU/load):** `rob_pop`=1 and `retire_count`+1. Next cycle, `rf_wr_*` present dest/tag/data with `rf_wr_valid`=1, unless dest==0, in which case `rf_wr_valid`=0.
  - **10 (branch/jump):** same write as 00, since jumps write the link register. If `head_mispredict`=1, the next state is FLUSH, and next cycle `clear`=1, `redirect_valid`=1 and `redirect_pc`=`head_target_pc`.
  - **01 (store):** no pop this cycle. `st_commit_req`=1 and `st_commit_tag` are driven starting next cycle, and the next state is STORE_WAIT.
  - **11 (halt):** `rob_pop`=1 and `retire_count`+1. Next state HALTED; `halt`=1 from the next cycle until `rst`.
- **STORE_WAIT:**
  - `st_commit_req` is held high.
  - When `rdy` and `st_commit_ack` are both 1: `rob_pop`=1, `retire_count`+1, state returns to RUN, and `st_commit_req` falls next cycle.
  - `st_commit_ack` is ignored in every other state.
- **FLUSH:** lasts exactly one cycle. No fire and no pop, even if the head is valid. Returns to RUN.
- **HALTED:** no further fires, pops or writes.
- **rdy=0:**
  - No state change, no pop, no counter change.
  - `rf_wr_valid`, `clear` and `redirect_valid` are forced 0 next cycle, so pulses never repeat.
  - `st_commit_req` and its tag hold their values.
- **Reset:**
  - All outputs 0, `retire_count`=0, state RUN.
  - `rst` during STORE_WAIT drops `st_commit_req` at the next edge; the pending ack is ignored.
- `retire_count` wraps from 2^32-1 to 0.
- The data fields of `rf_wr_*` and `redirect_pc` hold their last values when their strobes are 0.

## Timing
- Fire in cycle N:
  - `rob_pop` is high in cycle N; the ROB advances its head at edge N→N+1.
  - `rf_wr_valid` is high in N+1 only.
- Back-to-back ALU/load/non-mispredicted branches retire one per cycle.
- Mispredict fired in cycle N:
  - `clear` and `redirect_valid` are high in N+1 only.
  - The state is FLUSH in N+1.
  - The earliest next fire is N+2.
  - The register write of the branch is also in N+1.
- Store fired in cycle N:
  - `st_commit_req` rises in N+1; the earliest ack is in N+1.
  - An ack in cycle M gives `rob_pop` in M and `st_commit_req` low in M+1.
  - The earliest next fire is M+1.
- Halt fired in cycle N: `halt` rises in N+1.

## Test plan
- **ALU burst:** 3 consecutive ready type-00 heads (x1←0x11, x2←0x22, x0←0x33) → `rob_pop` high 3 cycles; `rf_wr_valid` pulses for x1 and x2 on successive cycles and stays 0 for x0; `retire_count`=3.
- **Mispredict:** type-10 head, dest x1, data 0x104, `head_mispredict`=1, target 0x200, with a ready ALU head queued behind it → N+1: `rf_wr`(x1,0x104), `clear`=1, `redirect_pc`=0x200; no fire in N+1; the queued head fires in N+2.
- **Store handshake:** type-01 head tag 5, ack delayed 4 cycles → `st_commit_req`=1 with tag 5 for 4 cycles; `rob_pop` in the ack cycle; `st_commit_req` low the next cycle; `retire_count`+1.
- **Halt:** type-11 head, then further ready heads → one pop, `halt` sticky 1, no further pops or writes until `rst`.
- **rdy stall:** `rdy`=0 for 3 cycles with a ready ALU head, and separately during STORE_WAIT with ack=1 → no pop, no write, `st_commit_req` held; the head retires exactly once after `rdy` returns.
- **Reset mid-store:** assert `rst` in STORE_WAIT → all outputs 0, `retire_count`=0; a stale ack afterwards causes no pop.
